// File: rtl/axi_mem_slave_pkg.sv
`default_nettype none
// axi_mem_slave_pkg: FSM state types and response codes shared by the AXI memory slave.
package axi_mem_slave_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_mem_slave_if.sv
`default_nettype none
// axi_mem_slave_if: AXI4 address/data/response bundle between a master and axi_mem_slave.
interface axi_mem_slave_if #(
   parameter int IDSIZE = 4,
   parameter int ASIZE  = 29,
   parameter int LSIZE  = 9,
   parameter int DSIZE  = 256
);
   logic [IDSIZE-1:0]  awid;
   logic [ASIZE-1:0]   awaddr;
   logic [LSIZE-1:0]   awlen;
   logic [2:0]         awsize;
   logic [1:0]         awburst;
   logic               awlock;
   logic [3:0]         awcache;
   logic [2:0]         awprot;
   logic [3:0]         awqos;
   logic               awvalid;
   logic               awready;

   logic [DSIZE-1:0]   wdata;
   logic [DSIZE/8-1:0] wstrb;
   logic               wlast;
   logic               wvalid;
   logic               wready;

   logic [IDSIZE-1:0]  bid;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;

   logic [IDSIZE-1:0]  arid;
   logic [ASIZE-1:0]   araddr;
   logic [LSIZE-1:0]   arlen;
   logic [2:0]         arsize;
   logic [1:0]         arburst;
   logic               arlock;
   logic [3:0]         arcache;
   logic [2:0]         arprot;
   logic [3:0]         arqos;
   logic               arvalid;
   logic               arready;

   logic [IDSIZE-1:0]  rid;
   logic [DSIZE-1:0]   rdata;
   logic [1:0]         rresp;
   logic               rlast;
   logic               rvalid;
   logic               rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface
`default_nettype wire

// File: rtl/axi_mem_slave_ram.sv
`default_nettype none
// axi_mem_slave_ram: DEPTH x DSIZE storage, byte-enabled synchronous write, asynchronous read.
module axi_mem_slave_ram #(
   parameter int DEPTH = 1024,
   parameter int DSIZE = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic               clk_i,
   input  wire logic               we_i,
   input  wire logic [AW-1:0]      waddr_i,
   input  wire logic [DSIZE-1:0]   wdata_i,
   input  wire logic [DSIZE/8-1:0] wstrb_i,
   input  wire logic [AW-1:0]      raddr_i,
   output logic      [DSIZE-1:0]   rdata_o
);
   logic [DSIZE-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DSIZE/8; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // Read sees pre-edge contents, so a same-cycle write is visible only next cycle.
   assign rdata_o = mem_q[raddr_i];
endmodule
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// axi_mem_slave: AXI4 INCR-burst memory slave with independent read/write FSMs and beat counters.
// Define AXI_MEM_SLAVE_BACKPRESSURE_EN to add LFSR-driven wready/rvalid stalls.
module axi_mem_slave
   import axi_mem_slave_pkg::*;
#(
   parameter int IDSIZE    = 4,
   parameter int ASIZE     = 29,
   parameter int LSIZE     = 9,
   parameter int DSIZE     = 256,
   parameter int ID        = 0,
   parameter int ADDR_STEP = 64,
   parameter int MEM_DEPTH = 1024
) (
   input  wire logic        axi_aclk,
   input  wire logic        axi_resetn,
   axi_mem_slave_if.slave   axi,
   output logic [31:0]      wr_beat_cnt,
   output logic [31:0]      rd_beat_cnt
);
   localparam int IDX_W   = $clog2(MEM_DEPTH);
   localparam int STEP_SH = $clog2(ADDR_STEP);
   localparam logic [IDSIZE-1:0] ID_RST = IDSIZE'(ID);

   wr_state_e         wr_state_q, wr_state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [LSIZE-1:0]  wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
   logic [IDSIZE-1:0] bid_q, bid_d;
   logic              wr_err_q, wr_err_d;
   logic [31:0]       wr_beat_cnt_q, wr_beat_cnt_d;

   rd_state_e         rd_state_q, rd_state_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [LSIZE-1:0]  rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
   logic [IDSIZE-1:0] rid_q, rid_d;
   logic [31:0]       rd_beat_cnt_q, rd_beat_cnt_d;

   logic             stall, wready, rvalid, w_fire, r_fire, wr_last, rd_last;
   logic [DSIZE-1:0] ram_rdata;
   logic             unused_ok;

`ifdef AXI_MEM_SLAVE_BACKPRESSURE_EN
   logic [7:0] lfsr_q, lfsr_d;
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) lfsr_q <= 8'hA5;
      else             lfsr_q <= lfsr_d;
   end
   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign wready  = (wr_state_q == W_DATA) && !stall;
   assign rvalid  = (rd_state_q == R_DATA) && !stall;
   assign w_fire  = wready && axi.wvalid;
   assign r_fire  = rvalid && axi.rready;
   assign wr_last = (wr_cnt_q == wr_len_q);
   assign rd_last = (rd_cnt_q == rd_len_q);

   assign axi.awready = (wr_state_q == W_IDLE);
   assign axi.wready  = wready;
   assign axi.bvalid  = (wr_state_q == W_RESP);
   assign axi.bid     = bid_q;
   assign axi.bresp   = (axi.bvalid && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
   assign axi.arready = (rd_state_q == R_IDLE);
   assign axi.rvalid  = rvalid;
   assign axi.rdata   = rvalid ? ram_rdata : '0;
   assign axi.rlast   = rvalid && rd_last;
   assign axi.rid     = rid_q;
   assign axi.rresp   = RESP_OKAY;
   assign wr_beat_cnt = wr_beat_cnt_q;
   assign rd_beat_cnt = rd_beat_cnt_q;

   // Sideband fields and address bits outside the beat index carry no meaning here.
   assign unused_ok = ^{axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot,
                        axi.awqos, axi.awaddr, axi.arsize, axi.arburst, axi.arlock,
                        axi.arcache, axi.arprot, axi.arqos, axi.araddr};

   always_comb begin
      wr_state_d    = wr_state_q;
      wr_idx_d      = wr_idx_q;
      wr_len_d      = wr_len_q;
      wr_cnt_d      = wr_cnt_q;
      bid_d         = bid_q;
      wr_err_d      = wr_err_q;
      wr_beat_cnt_d = wr_beat_cnt_q;
      unique case (wr_state_q)
         W_IDLE: if (axi.awvalid) begin
            wr_state_d = W_DATA;
            wr_idx_d   = axi.awaddr[STEP_SH +: IDX_W];
            wr_len_d   = axi.awlen;
            wr_cnt_d   = '0;
            bid_d      = axi.awid;
            wr_err_d   = 1'b0;
         end
         W_DATA: if (w_fire) begin
            wr_idx_d      = wr_idx_q + IDX_W'(1);
            wr_cnt_d      = wr_cnt_q + LSIZE'(1);
            wr_beat_cnt_d = wr_beat_cnt_q + 32'd1;
            // wlast only flags a protocol error; awlen alone decides the burst end.
            if (axi.wlast != wr_last) wr_err_d = 1'b1;
            if (wr_last) wr_state_d = W_RESP;
         end
         W_RESP: if (axi.bready) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d    = rd_state_q;
      rd_idx_d      = rd_idx_q;
      rd_len_d      = rd_len_q;
      rd_cnt_d      = rd_cnt_q;
      rid_d         = rid_q;
      rd_beat_cnt_d = rd_beat_cnt_q;
      unique case (rd_state_q)
         R_IDLE: if (axi.arvalid) begin
            rd_state_d = R_DATA;
            rd_idx_d   = axi.araddr[STEP_SH +: IDX_W];
            rd_len_d   = axi.arlen;
            rd_cnt_d   = '0;
            rid_d      = axi.arid;
         end
         R_DATA: if (r_fire) begin
            rd_idx_d      = rd_idx_q + IDX_W'(1);
            rd_cnt_d      = rd_cnt_q + LSIZE'(1);
            rd_beat_cnt_d = rd_beat_cnt_q + 32'd1;
            if (rd_last) rd_state_d = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_state_q    <= W_IDLE;
         wr_idx_q      <= '0;
         wr_len_q      <= '0;
         wr_cnt_q      <= '0;
         bid_q         <= ID_RST;
         wr_err_q      <= 1'b0;
         wr_beat_cnt_q <= '0;
         rd_state_q    <= R_IDLE;
         rd_idx_q      <= '0;
         rd_len_q      <= '0;
         rd_cnt_q      <= '0;
         rid_q         <= ID_RST;
         rd_beat_cnt_q <= '0;
      end else begin
         wr_state_q    <= wr_state_d;
         wr_idx_q      <= wr_idx_d;
         wr_len_q      <= wr_len_d;
         wr_cnt_q      <= wr_cnt_d;
         bid_q         <= bid_d;
         wr_err_q      <= wr_err_d;
         wr_beat_cnt_q <= wr_beat_cnt_d;
         rd_state_q    <= rd_state_d;
         rd_idx_q      <= rd_idx_d;
         rd_len_q      <= rd_len_d;
         rd_cnt_q      <= rd_cnt_d;
         rid_q         <= rid_d;
         rd_beat_cnt_q <= rd_beat_cnt_d;
      end
   end

   axi_mem_slave_ram #(
      .DEPTH (MEM_DEPTH),
      .DSIZE (DSIZE),
      .AW    (IDX_W)
   ) u_ram (
      .clk_i   (axi_aclk),
      .we_i    (w_fire),
      .waddr_i (wr_idx_q),
      .wdata_i (axi.wdata),
      .wstrb_i (axi.wstrb),
      .raddr_i (rd_idx_q),
      .rdata_o (ram_rdata)
   );
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// tb_axi_mem_slave: directed bursts against a transaction-level memory model checked every cycle.
module tb_axi_mem_slave;
   logic        clk;
   logic        rst_n;
   logic [31:0] wr_cnt, rd_cnt;

   axi_mem_slave_if #(.IDSIZE(4), .ASIZE(29), .LSIZE(9), .DSIZE(256)) axi ();

   axi_mem_slave #(
      .IDSIZE(4), .ASIZE(29), .LSIZE(9), .DSIZE(256),
      .ID(0), .ADDR_STEP(64), .MEM_DEPTH(1024)
   ) dut (
      .axi_aclk    (clk),
      .axi_resetn  (rst_n),
      .axi         (axi),
      .wr_beat_cnt (wr_cnt),
      .rd_beat_cnt (rd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Transaction-level model: memory image, burst progress and running beat totals.
   logic [255:0] m_mem [1024];
   int           m_wphase;
   int           m_widx, m_wlen, m_wbeat;
   logic [3:0]   m_bid;
   bit           m_werr;
   bit           m_ractive;
   int           m_ridx, m_rlen, m_rbeat;
   logic [3:0]   m_rid;
   logic [31:0]  m_wcnt, m_rcnt;

   logic [255:0] got_rdata [$];
   bit           got_rlast [$];
   logic [1:0]   got_bresp;
   logic [3:0]   got_bid;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_awready", 256'(axi.awready), 256'(1));
         check("rst_wready",  256'(axi.wready),  256'(0));
         check("rst_bvalid",  256'(axi.bvalid),  256'(0));
         check("rst_arready", 256'(axi.arready), 256'(1));
         check("rst_rvalid",  256'(axi.rvalid),  256'(0));
         check("rst_rlast",   256'(axi.rlast),   256'(0));
         check("rst_bid_rid", 256'({axi.bid, axi.rid}), 256'(0));
         check("rst_resp",    256'({axi.bresp, axi.rresp}), 256'(0));
         check("rst_cnts",    256'({wr_cnt, rd_cnt}), 256'(0));
         m_wphase  = 0;
         m_ractive = 0;
         m_wcnt    = 0;
         m_rcnt    = 0;
      end else begin
         check("awready", 256'(axi.awready), 256'(m_wphase == 0));
`ifndef AXI_MEM_SLAVE_BACKPRESSURE_EN
         check("wready",  256'(axi.wready),  256'(m_wphase == 1));
         check("rvalid",  256'(axi.rvalid),  256'(m_ractive));
`endif
         check("bvalid",  256'(axi.bvalid),  256'(m_wphase == 2));
         check("arready", 256'(axi.arready), 256'(!m_ractive));
         check("wr_cnt",  256'(wr_cnt), 256'(m_wcnt));
         check("rd_cnt",  256'(rd_cnt), 256'(m_rcnt));
         if (m_wphase == 2) begin
            check("bid",   256'(axi.bid),   256'(m_bid));
            check("bresp", 256'(axi.bresp), 256'(m_werr ? 2'b10 : 2'b00));
         end
         if (axi.rvalid) begin
            check("rdata", axi.rdata, m_mem[m_ridx]);
            check("rlast", 256'(axi.rlast), 256'(m_rbeat == m_rlen));
            check("rid",   256'(axi.rid),   256'(m_rid));
            check("rresp", 256'(axi.rresp), 256'(0));
         end else begin
            check("rdata_idle", axi.rdata, 256'(0));
            check("rlast_idle", 256'(axi.rlast), 256'(0));
         end
         // Read side advances before the write image so same-cycle reads see old data.
         if (!m_ractive) begin
            if (axi.arvalid) begin
               m_ractive = 1;
               m_ridx    = int'(axi.araddr / 64) % 1024;
               m_rlen    = int'(axi.arlen);
               m_rbeat   = 0;
               m_rid     = axi.arid;
            end
         end else if (axi.rvalid && axi.rready) begin
            got_rdata.push_back(axi.rdata);
            got_rlast.push_back(axi.rlast);
            m_rcnt = m_rcnt + 1;
            m_ridx = (m_ridx + 1) % 1024;
            if (m_rbeat == m_rlen) m_ractive = 0;
            else m_rbeat++;
         end
         case (m_wphase)
            0: if (axi.awvalid) begin
               m_wphase = 1;
               m_widx   = int'(axi.awaddr / 64) % 1024;
               m_wlen   = int'(axi.awlen);
               m_wbeat  = 0;
               m_bid    = axi.awid;
               m_werr   = 0;
            end
            1: if (axi.wvalid && axi.wready) begin
               for (int b = 0; b < 32; b++)
                  if (axi.wstrb[b]) m_mem[m_widx][b*8 +: 8] = axi.wdata[b*8 +: 8];
               m_wcnt = m_wcnt + 1;
               m_widx = (m_widx + 1) % 1024;
               if (axi.wlast != (m_wbeat == m_wlen)) m_werr = 1;
               if (m_wbeat == m_wlen) m_wphase = 2;
               else m_wbeat++;
            end
            default: if (axi.bready) m_wphase = 0;
         endcase
      end
   end

   task automatic wait_hs(input int sel, input string what);
      bit ok = 0;
      for (int n = 0; n < 64 && !ok; n++) begin
         @(negedge clk);
         case (sel)
            0: ok = axi.awready;
            1: ok = axi.wready;
            2: ok = axi.bvalid;
            default: ok = axi.arready;
         endcase
      end
      if (!ok) check({what, "_timeout"}, 256'(0), 256'(1));
   endtask

   task automatic do_write(input int addr, input logic [3:0] id, input int len,
                           input logic [255:0] d [4], input bit [3:0] lastm,
                           input logic [31:0] strb);
      axi.awaddr = 29'(addr); axi.awid = id; axi.awlen = 9'(len); axi.awvalid = 1;
      wait_hs(0, "aw");
      @(posedge clk); #1;
      axi.awvalid = 0;
      for (int i = 0; i <= len; i++) begin
         axi.wvalid = 1; axi.wdata = d[i]; axi.wstrb = strb; axi.wlast = lastm[i];
         wait_hs(1, "w");
         @(posedge clk); #1;
      end
      axi.wvalid = 0; axi.wlast = 0;
      wait_hs(2, "b");
      got_bresp = axi.bresp;
      got_bid   = axi.bid;
      @(posedge clk); #1;
   endtask

   task automatic do_read(input int addr, input logic [3:0] id, input int len,
                          input int hold_cycles);
      bit held = 0;
      got_rdata.delete(); got_rlast.delete();
      axi.araddr = 29'(addr); axi.arid = id; axi.arlen = 9'(len); axi.arvalid = 1;
      wait_hs(3, "ar");
      @(posedge clk); #1;
      axi.arvalid = 0;
      axi.rready  = 1;
      for (int n = 0; n < 64 && got_rdata.size() < len + 1; n++) begin
         if (hold_cycles > 0 && !held && got_rdata.size() == 1) begin
            axi.rready = 0;
            repeat (hold_cycles) @(posedge clk);
            #1;
            axi.rready = 1;
            held = 1;
         end
         @(posedge clk); #1;
      end
      check("rd_beats", 256'(got_rdata.size()), 256'(len + 1));
   endtask

   task automatic check_rd(input string name, input logic [255:0] e [4], input int n);
      for (int i = 0; i < n; i++) begin
         check({name, "_data"}, (i < got_rdata.size()) ? got_rdata[i] : 256'hx, e[i]);
         check({name, "_last"}, (i < got_rlast.size()) ? 256'(got_rlast[i]) : 256'hx,
               256'(i == n - 1));
      end
   endtask

   logic [255:0] d [4];
   logic [255:0] e [4];
   localparam logic [255:0] VA = {8{32'hA0A0_0001}};
   localparam logic [255:0] VB = {8{32'hB0B0_0002}};

   initial begin
      rst_n = 0;
      axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0;
      axi.awsize = 3'd5; axi.awburst = 2'b01; axi.awlock = 0; axi.awcache = 0;
      axi.awprot = 0; axi.awqos = 0;
      axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 1;
      axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0;
      axi.arsize = 3'd5; axi.arburst = 2'b01; axi.arlock = 0; axi.arcache = 0;
      axi.arprot = 0; axi.arqos = 0; axi.rready = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;

      d = '{256'd1, 256'd2, 256'd3, 256'd4};
      do_write(0, 4'd5, 3, d, 4'b1000, '1);
      check("t1_bresp", 256'(got_bresp), 256'(0));
      check("t1_bid",   256'(got_bid),   256'(5));
      check("t1_wrcnt", 256'(wr_cnt),    256'(4));

      do_read(0, 4'd6, 3, 0);
      e = '{256'd1, 256'd2, 256'd3, 256'd4};
      check_rd("t2", e, 4);
      check("t2_rdcnt", 256'(rd_cnt), 256'(4));

      do_read(128, 4'd2, 0, 0);
      e = '{256'd3, 256'd0, 256'd0, 256'd0};
      check_rd("t3", e, 1);

      d = '{VA, VB, 256'd0, 256'd0};
      do_write(1023 * 64, 4'd7, 1, d, 4'b0001, '1);
      check("t4_bresp", 256'(got_bresp), 256'(2'b10));
      check("t4_wrcnt", 256'(wr_cnt),    256'(6));
      do_read(0, 4'd1, 0, 0);
      e = '{VB, 256'd0, 256'd0, 256'd0};
      check_rd("t4_idx0", e, 1);
      do_read(1023 * 64, 4'd3, 1, 0);
      e = '{VA, VB, 256'd0, 256'd0};
      check_rd("t4_wrap", e, 2);

      d = '{'1, 256'd0, 256'd0, 256'd0};
      do_write(128, 4'd4, 0, d, 4'b0001, 32'h1);
      check("t5_bresp", 256'(got_bresp), 256'(0));
      do_read(128, 4'd4, 0, 0);
      e = '{256'hFF, 256'd0, 256'd0, 256'd0};
      check_rd("t5_strb", e, 1);

      do_read(0, 4'd9, 3, 3);
      e = '{VB, 256'd2, 256'hFF, 256'd4};
      check_rd("t6_hold", e, 4);
      check("t6_rdcnt", 256'(rd_cnt), 256'(13));

      axi.awaddr = 29'(640); axi.awid = 4'd9; axi.awlen = 9'd3; axi.awvalid = 1;
      wait_hs(0, "t7_aw");
      @(posedge clk); #1;
      axi.awvalid = 0;
      axi.wvalid = 1; axi.wstrb = '1; axi.wdata = 256'h77;
      wait_hs(1, "t7_w0");
      @(posedge clk); #1;
      axi.wdata = 256'h88;
      wait_hs(1, "t7_w1");
      @(posedge clk); #1;
      axi.wvalid = 0;
      rst_n = 0;
      #1;
      check("t7_wready",  256'(axi.wready),  256'(0));
      check("t7_bvalid",  256'(axi.bvalid),  256'(0));
      check("t7_awready", 256'(axi.awready), 256'(1));
      check("t7_cnts",    256'({wr_cnt, rd_cnt}), 256'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      do_read(640, 4'd8, 1, 0);
      e = '{256'h77, 256'h88, 256'd0, 256'd0};
      check_rd("t7_persist", e, 2);
      check("t7_rdcnt", 256'(rd_cnt), 256'(2));
      check("t7_wrcnt", 256'(wr_cnt), 256'(0));

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
